spi_frame_master: RTL and testbench

//  Host-side SPI transmitter for the HUB75 panel link. On a start pulse it reads FRAME_BYTES bytes

---
 rtl/spi_frame_master.sv | 207 ++++++++++++++++++++
 tb/tb_spi_frame_master.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_master.sv
// spi_frame_master: host-side SPI mode-0 transmitter for the HUB75 panel link.
// On a start pulse it streams FRAME_BYTES bytes from a synchronous byte RAM,
// MSB first, within one CS-low burst. Every output comes straight from a flop.
module spi_frame_master #(
    parameter int FRAME_BYTES = 16384,
    parameter int ADDR_W      = 14,
    parameter int CLK_DIV     = 2,
    parameter int CS_SETUP    = 2,
    parameter int CS_HOLD     = 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [7:0]        mem_rdata,
    output logic              spi_clk,
    output logic              spi_mosi,
    output logic              spi_cs,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_FETCH = 3'd2,
        ST_SHIFT = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    localparam int CNT_W = 16;
    // SETUP stays one clock longer than CS_SETUP so that the accept cycle plus
    // CS_SETUP clocks elapse before the first fetch.
    localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(CS_SETUP);
    localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(FRAME_BYTES - 1);

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [2:0]         bit_cnt_r, bit_cnt_s;
    logic [ADDR_W-1:0]  byte_idx_r, byte_idx_s;
    logic [7:0]         shift_r, shift_s;
    logic [ADDR_W-1:0]  raddr_r, raddr_s;
    logic               spi_clk_r, spi_clk_s;
    logic               spi_mosi_r, spi_mosi_s;
    logic               spi_cs_r, spi_cs_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;

    assign mem_raddr = raddr_r;
    assign spi_clk   = spi_clk_r;
    assign spi_mosi  = spi_mosi_r;
    assign spi_cs    = spi_cs_r;
    assign busy      = busy_r;
    assign done      = done_r;

    // Next-state and next-output computation; abort outranks every transition.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        bit_cnt_s  = bit_cnt_r;
        byte_idx_s = byte_idx_r;
        shift_s    = shift_r;
        raddr_s    = raddr_r;
        spi_clk_s  = spi_clk_r;
        spi_mosi_s = spi_mosi_r;
        spi_cs_s   = spi_cs_r;
        busy_s     = busy_r;
        done_s     = 1'b0;

        if (abort && (state_r != ST_IDLE)) begin
            // Drop the link to its idle levels; the partial byte is lost and
            // the next frame starts again from address 0.
            state_s    = ST_IDLE;
            cnt_s      = '0;
            bit_cnt_s  = 3'd0;
            byte_idx_s = '0;
            shift_s    = 8'h00;
            raddr_s    = '0;
            spi_clk_s  = 1'b0;
            spi_mosi_s = 1'b0;
            spi_cs_s   = 1'b1;
            busy_s     = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // A start coinciding with the done pulse is not a new frame.
                    if (start && !done_r) begin
                        state_s    = ST_SETUP;
                        cnt_s      = '0;
                        bit_cnt_s  = 3'd0;
                        byte_idx_s = '0;
                        raddr_s    = '0;
                        spi_cs_s   = 1'b0;
                        busy_s     = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    if (cnt_r == SETUP_LAST) begin
                        state_s = ST_FETCH;
                        cnt_s   = '0;
                        raddr_s = byte_idx_r;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                ST_FETCH: begin
                    // First clock: address is on the RAM. Second clock: data is valid.
                    if (cnt_r == '0) begin
                        cnt_s = CNT_W'(1);
                    end else begin
                        shift_s    = mem_rdata;
                        spi_mosi_s = mem_rdata[7];
                        cnt_s      = '0;
                        bit_cnt_s  = 3'd0;
                        state_s    = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_r != HALF_LAST) begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end else begin
                        cnt_s = '0;
                        if (!spi_clk_r) begin
                            spi_clk_s = 1'b1;
                        end else begin
                            // Falling edge: advance to the next bit while sclk is low.
                            spi_clk_s  = 1'b0;
                            shift_s    = {shift_r[6:0], 1'b0};
                            spi_mosi_s = shift_r[6];
                            if (bit_cnt_r == 3'd7) begin
                                bit_cnt_s = 3'd0;
                                if (byte_idx_r == LAST_IDX) begin
                                    state_s = ST_HOLD;
                                end else begin
                                    byte_idx_s = byte_idx_r + ADDR_W'(1);
                                    raddr_s    = byte_idx_r + ADDR_W'(1);
                                    state_s    = ST_FETCH;
                                end
                            end else begin
                                bit_cnt_s = bit_cnt_r + 3'd1;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt_r == HOLD_LAST) begin
                        state_s    = ST_IDLE;
                        cnt_s      = '0;
                        spi_cs_s   = 1'b1;
                        spi_mosi_s = 1'b0;
                        busy_s     = 1'b0;
                        done_s     = 1'b1;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    // Unreachable encodings recover to a quiet idle link.
                    state_s    = ST_IDLE;
                    cnt_s      = '0;
                    bit_cnt_s  = 3'd0;
                    byte_idx_s = '0;
                    raddr_s    = '0;
                    spi_clk_s  = 1'b0;
                    spi_mosi_s = 1'b0;
                    spi_cs_s   = 1'b1;
                    busy_s     = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset forces the idle link levels immediately.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            bit_cnt_r  <= 3'd0;
            byte_idx_r <= '0;
            shift_r    <= 8'h00;
            raddr_r    <= '0;
            spi_clk_r  <= 1'b0;
            spi_mosi_r <= 1'b0;
            spi_cs_r   <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            byte_idx_r <= byte_idx_s;
            shift_r    <= shift_s;
            raddr_r    <= raddr_s;
            spi_clk_r  <= spi_clk_s;
            spi_mosi_r <= spi_mosi_s;
            spi_cs_r   <= spi_cs_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master with a 4-byte frame: byte RAM model, SPI slave
// model sampling on rising spi_clk, table of frame vectors, and hand-written
// sequences for mid-frame start, abort and asynchronous reset.
module tb_spi_frame_master;

    localparam int FB  = 4;
    localparam int AW  = 14;
    localparam int CD  = 2;
    localparam int CSS = 2;
    localparam int CSH = 2;

    logic          clock = 1'b0;
    logic          resetn = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] mem_raddr;
    logic [7:0]    mem_rdata;
    logic          spi_clk, spi_mosi, spi_cs, busy, done;

    logic [7:0]    ram [4];
    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            t0 = 0;

    // slave / link monitors
    logic [31:0]   rx_all = 32'h0;
    int            rises = 0;
    int            done_cnt = 0;
    int            done_cyc = -1;
    int            cs_falls = 0;
    int            mosi_viol = 0;
    int            hi_viol = 0;
    int            hi_len = 0;
    logic          prev_cs = 1'b1;
    logic          prev_clk = 1'b0;
    logic          prev_mosi = 1'b0;

    typedef struct {
        string       name;
        logic [31:0] ram_word;
        logic [31:0] exp_word;
        int          exp_rises;
        int          exp_lat;
    } vec_t;

    vec_t vecs [4];

    always #5 clock = ~clock;

    spi_frame_master #(
        .FRAME_BYTES(FB), .ADDR_W(AW), .CLK_DIV(CD), .CS_SETUP(CSS), .CS_HOLD(CSH)
    ) dut (
        .clock(clock), .resetn(resetn), .start(start), .abort(abort),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs(spi_cs),
        .busy(busy), .done(done)
    );

    always @(posedge clock) mem_rdata <= ram[mem_raddr[1:0]];
    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge spi_clk) begin
        if (spi_cs == 1'b0) begin
            rx_all = {rx_all[30:0], spi_mosi};
            rises  = rises + 1;
        end
    end

    always @(negedge clock) begin
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (prev_cs && !spi_cs) cs_falls = cs_falls + 1;
        if (spi_cs && spi_mosi) mosi_viol = mosi_viol + 1;
        if (prev_clk && spi_clk && (spi_mosi != prev_mosi)) mosi_viol = mosi_viol + 1;
        if (spi_clk) begin
            hi_len = hi_len + 1;
        end else begin
            if (prev_clk && (hi_len != CD)) hi_viol = hi_viol + 1;
            hi_len = 0;
        end
        prev_cs   = spi_cs;
        prev_clk  = spi_clk;
        prev_mosi = spi_mosi;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        rx_all    = 32'h0;
        rises     = 0;
        done_cnt  = 0;
        done_cyc  = -1;
        cs_falls  = 0;
        mosi_viol = 0;
        hi_viol   = 0;
        hi_len    = 0;
    endtask

    task automatic load_ram(input logic [31:0] w);
        for (int i = 0; i < 4; i++) ram[i] = w[31-8*i -: 8];
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        t0 = cyc;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clock);
            if (done) got = 1'b1;
        end
    endtask

    task automatic run_frame(input logic [31:0] w, output bit got);
        load_ram(w);
        clear_mon();
        pulse_start();
        wait_done(400, got);
        repeat (3) @(negedge clock);
    endtask

    initial begin
        bit got;

        vecs[0] = '{"pattern_a5", 32'hA53CFF00, 32'hA53CFF00, 32, 141};
        vecs[1] = '{"zeros_one",  32'h00000001, 32'h00000001, 32, 141};
        vecs[2] = '{"edges",      32'h807F55AA, 32'h807F55AA, 32, 141};
        vecs[3] = '{"all_ones",   32'hFFFFFFFF, 32'hFFFFFFFF, 32, 141};
        load_ram(32'hA53CFF00);

        // Reset values before any clock edge
        #1 resetn = 1'b0;
        #1;
        check("rst_cs",    32'(spi_cs),    32'h1);
        check("rst_clk",   32'(spi_clk),   32'h0);
        check("rst_mosi",  32'(spi_mosi),  32'h0);
        check("rst_busy",  32'(busy),      32'h0);
        check("rst_done",  32'(done),      32'h0);
        check("rst_raddr", 32'(mem_raddr), 32'h0);
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        repeat (2) @(negedge clock);

        // Table-driven full frames
        for (int v = 0; v < 4; v++) begin
            run_frame(vecs[v].ram_word, got);
            check({vecs[v].name, "_done_seen"}, 32'(got), 32'h1);
            check({vecs[v].name, "_data"}, rx_all, vecs[v].exp_word);
            check({vecs[v].name, "_rises"}, 32'(rises), 32'(vecs[v].exp_rises));
            check({vecs[v].name, "_latency"}, 32'(done_cyc - (t0 + 1)), 32'(vecs[v].exp_lat));
            check({vecs[v].name, "_done_cnt"}, 32'(done_cnt), 32'h1);
            check({vecs[v].name, "_cs_falls"}, 32'(cs_falls), 32'h1);
            check({vecs[v].name, "_mosi_rules"}, 32'(mosi_viol), 32'h0);
            check({vecs[v].name, "_sclk_high"}, 32'(hi_viol), 32'h0);
            check({vecs[v].name, "_idle_cs"}, 32'(spi_cs), 32'h1);
            check({vecs[v].name, "_idle_busy"}, 32'(busy), 32'h0);
        end

        // start mid-frame and in the done cycle is ignored
        load_ram(32'hA53CFF00);
        clear_mon();
        pulse_start();
        check("busy_after_start", 32'(busy), 32'h1);
        repeat (60) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(200, got);
        check("ign_done_seen", 32'(got), 32'h1);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (30) @(negedge clock);
        check("ign_done_cnt", 32'(done_cnt), 32'h1);
        check("ign_cs_falls", 32'(cs_falls), 32'h1);
        check("ign_latency", 32'(done_cyc - (t0 + 1)), 32'd141);
        check("ign_data", rx_all, 32'hA53CFF00);
        check("ign_busy", 32'(busy), 32'h0);
        check("ign_cs", 32'(spi_cs), 32'h1);

        // abort during the third bit of byte index 1 (rising edge due at E49)
        clear_mon();
        pulse_start();
        repeat (48) @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_cs", 32'(spi_cs), 32'h1);
        check("abort_clk", 32'(spi_clk), 32'h0);
        check("abort_mosi", 32'(spi_mosi), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        repeat (200) @(negedge clock);
        check("abort_no_done", 32'(done_cnt), 32'h0);
        check("abort_rises", 32'(rises), 32'd10);
        check("abort_bits", 32'(rx_all[9:0]), 32'h294);
        check("abort_cs_falls", 32'(cs_falls), 32'h1);
        run_frame(32'hA53CFF00, got);
        check("reabort_done_seen", 32'(got), 32'h1);
        check("reabort_first", 32'(rx_all[31:24]), 32'hA5);
        check("reabort_data", rx_all, 32'hA53CFF00);

        // asynchronous reset with spi_clk high mid-SHIFT
        clear_mon();
        pulse_start();
        repeat (40) @(negedge clock);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (spi_clk) got = 1'b1;
            else @(negedge clock);
        end
        check("areset_sclk_high_found", 32'(got), 32'h1);
        #2 resetn = 1'b0;
        #1;
        check("areset_clk", 32'(spi_clk), 32'h0);
        check("areset_cs", 32'(spi_cs), 32'h1);
        check("areset_mosi", 32'(spi_mosi), 32'h0);
        check("areset_busy", 32'(busy), 32'h0);
        check("areset_raddr", 32'(mem_raddr), 32'h0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        repeat (5) @(negedge clock);
        check("areset_idle_busy", 32'(busy), 32'h0);
        run_frame(32'h807F55AA, got);
        check("areset_done_seen", 32'(got), 32'h1);
        check("areset_data", rx_all, 32'h807F55AA);
        check("areset_latency", 32'(done_cyc - (t0 + 1)), 32'd141);
        check("areset_done_cnt", 32'(done_cnt), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
